am_sample_scheduler: RTL and testbench

Sequences amplitude samples into the AM PWM modulator of the SDR transmitter.
- Buffers incoming samples from the upstream source (UART/SPI/NCO) in a small FIFO.
- Scales each sample to a PWM duty word.
- Loads the duty word only on PWM frame boundaries, so the modulator never sees a mid-frame change.
- Handles priming, underrun and enable/disable without glitching the carrier.

---
 rtl/am_sample_scheduler_pkg.sv | 22 ++
 rtl/am_sample_scheduler_sample_fifo.sv | 72 +++++++
 rtl/am_sample_scheduler.sv | 160 ++++++++++++++++
 tb/tb_am_sample_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_sample_scheduler_pkg.sv
// Shared constants, state encoding and width helpers for the AM sample scheduler.
package am_sample_scheduler_pkg;

    localparam int unsigned AM_PWM_STEPS_DEF         = 100;
    localparam int unsigned AM_CLKS_IN_PWM_STEPS_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_e;

    function automatic int unsigned duty_w(input int unsigned steps);
        return $clog2(steps + 1);
    endfunction

    // Counter width that stays legal for a modulus of 1.
    function automatic int unsigned ctr_w(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/am_sample_scheduler_sample_fifo.sv
// First-word fall-through sample FIFO with synchronous flush.
module am_sample_scheduler_sample_fifo
    import am_sample_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = ctr_w(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               do_push, do_pop;

    assign full    = (level_q == LEVEL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer/level update; flush wins over any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LEVEL_W'(1);
                2'b01:   level_d = level_q - LEVEL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/am_sample_scheduler.sv
// Feeds buffered, scaled amplitude samples to the AM PWM modulator, changing
// the duty word only on PWM frame boundaries.
module am_sample_scheduler
    import am_sample_scheduler_pkg::*;
#(
    parameter int unsigned AM_PWM_STEPS         = AM_PWM_STEPS_DEF,
    parameter int unsigned AM_CLKS_IN_PWM_STEPS = AM_CLKS_IN_PWM_STEPS_DEF,
    parameter int unsigned SAMPLE_W             = 8,
    parameter int unsigned FIFO_DEPTH           = 8,
    parameter int unsigned PRIME_LEVEL          = 4,
    parameter int unsigned FRAMES_PER_SAMPLE    = 4,
    localparam int unsigned DUTY_W  = duty_w(AM_PWM_STEPS),
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DUTY_W-1:0]   duty,
    output logic                duty_valid,
    output logic                frame_start,
    output logic                underrun,
    input  logic                clr_underrun,
    output logic [LEVEL_W-1:0]  level
);

    localparam int unsigned FRAME_LEN = AM_PWM_STEPS * AM_CLKS_IN_PWM_STEPS;
    localparam int unsigned CNT_W     = ctr_w(FRAME_LEN);
    localparam int unsigned SPF_W     = ctr_w(FRAMES_PER_SAMPLE);
    localparam int unsigned PROD_W    = SAMPLE_W + DUTY_W;
    localparam logic [DUTY_W-1:0] IDLE_DUTY = DUTY_W'(AM_PWM_STEPS / 2);

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SPF_W-1:0]    spf_q, spf_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                dv_q, dv_d;
    logic                ur_q, ur_d;
    logic                ur_set;

    logic                boundary, due;
    logic [PROD_W-1:0]   prod;
    logic [DUTY_W-1:0]   scaled;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [LEVEL_W-1:0]  fifo_level;

    am_sample_scheduler_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (s_data),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Disabling drains the buffer at once so a re-enable always re-primes fresh data.
    assign s_ready     = !rst && en && !fifo_full;
    assign fifo_push   = s_valid && s_ready;
    assign fifo_flush  = !en;
    assign frame_start = !rst && (cnt_q == '0);
    assign duty        = duty_q;
    assign duty_valid  = dv_q;
    assign underrun    = ur_q;
    assign level       = fifo_level;

    always_comb begin
        boundary = (cnt_q == CNT_W'(FRAME_LEN - 1));
        cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
        due      = (spf_q == SPF_W'(FRAMES_PER_SAMPLE - 1));
        prod     = PROD_W'(fifo_dout) * PROD_W'(AM_PWM_STEPS);
        scaled   = DUTY_W'(prod >> SAMPLE_W);
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        dv_d     = 1'b0;
        fifo_pop = 1'b0;
        ur_set   = 1'b0;
        spf_d    = spf_q;
        if (boundary) begin
            spf_d = due ? '0 : spf_q + SPF_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_PRIME;
                        duty_d  = IDLE_DUTY;
                        dv_d    = 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                        dv_d    = 1'b1;
                    end else if (fifo_level >= LEVEL_W'(PRIME_LEVEL)) begin
                        state_d  = ST_RUN;
                        fifo_pop = 1'b1;
                        duty_d   = scaled;
                        dv_d     = 1'b1;
                        spf_d    = '0;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                        dv_d    = 1'b1;
                    end else if (due && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        duty_d   = scaled;
                        dv_d     = 1'b1;
                    end else if (due) begin
                        // Starved: fall back to the bare carrier and re-prime.
                        ur_set  = 1'b1;
                        duty_d  = IDLE_DUTY;
                        dv_d    = 1'b1;
                        state_d = ST_PRIME;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end
            endcase
        end
        ur_d = ur_set || (ur_q && !clr_underrun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            spf_q   <= '0;
            duty_q  <= '0;
            dv_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spf_q   <= spf_d;
            duty_q  <= duty_d;
            dv_q    <= dv_d;
            ur_q    <= ur_d;
        end
    end

endmodule

// File: tb/tb_am_sample_scheduler.sv
// Scoreboard bench for am_sample_scheduler: a frame-level reference model
// predicts every output and duty load; a negedge monitor compares.
module tb_am_sample_scheduler;

    localparam int FL     = 100;
    localparam int DEPTH  = 8;
    localparam int PRIME  = 4;
    localparam int FPS    = 4;
    localparam int IDLE_D = 50;

    logic       clk = 1'b0;
    logic       rst, en, s_valid, clr_underrun;
    logic [7:0] s_data;
    logic       s_ready, duty_valid, frame_start, underrun;
    logic [6:0] duty;
    logic [3:0] level;

    always #5 clk = ~clk;

    am_sample_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .level        (level)
    );

    typedef enum int {M_IDLE, M_PRIME, M_RUN} mode_e;
    typedef struct { int c; int d; } ev_t;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    bit    m_live = 1'b0;
    int    m_t, m_duty, m_f0;
    bit    m_ur;
    mode_e m_mode;
    int    m_q[$];
    ev_t   exp_q[$];
    int    dv_log[$];

    function automatic int scale(input int s);
        return (s * FL) / 256;
    endfunction

    task automatic note_fail();
        miscompares++;
        if (miscompares >= 200) begin
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
            note_fail();
        end
    endtask

    // Reference model: frame position from elapsed cycles, sample due every FPS frames since RUN entry.
    bit mb_bnd, mb_push, mb_pop, mb_dv, mb_set;
    int mb_nf, mb_nd;
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_live = 1'b1;
            m_t = 0; m_duty = 0; m_f0 = 0; m_ur = 1'b0; m_mode = M_IDLE;
            m_q.delete();
            exp_q.delete();
        end else if (m_live) begin
            mb_bnd  = (m_t % FL) == FL - 1;
            mb_nf   = m_t / FL + 1;
            mb_push = s_valid && en && (m_q.size() < DEPTH);
            mb_pop = 1'b0; mb_dv = 1'b0; mb_set = 1'b0; mb_nd = m_duty;
            if (mb_bnd) begin
                if (m_mode == M_IDLE) begin
                    if (en) begin m_mode = M_PRIME; mb_nd = IDLE_D; mb_dv = 1'b1; end
                end else if (!en) begin
                    m_mode = M_IDLE; mb_nd = 0; mb_dv = 1'b1;
                end else if (m_mode == M_PRIME) begin
                    if (m_q.size() >= PRIME) begin
                        m_mode = M_RUN; mb_pop = 1'b1; mb_nd = scale(m_q[0]); mb_dv = 1'b1; m_f0 = mb_nf;
                    end
                end else if ((mb_nf - m_f0) % FPS == 0) begin
                    if (m_q.size() > 0) begin
                        mb_pop = 1'b1; mb_nd = scale(m_q[0]); mb_dv = 1'b1;
                    end else begin
                        mb_set = 1'b1; mb_nd = IDLE_D; mb_dv = 1'b1; m_mode = M_PRIME;
                    end
                end
            end
            if (!en) m_q.delete();
            else begin
                if (mb_pop)  void'(m_q.pop_front());
                if (mb_push) m_q.push_back(int'(s_data));
            end
            if (mb_set) m_ur = 1'b1;
            else if (clr_underrun) m_ur = 1'b0;
            m_duty = mb_nd;
            if (mb_dv) exp_q.push_back('{c: cyc, d: mb_nd});
            m_t++;
        end
    end

    // Monitor: whole visible state every cycle, plus scoreboard of duty loads.
    bit  mo_rdy, mo_fs, mo_dv;
    ev_t mo_e;
    always @(negedge clk) begin
        if (m_live) begin
            mo_rdy = !rst && en && (m_q.size() < DEPTH);
            mo_fs  = !rst && (m_t % FL == 0);
            vectors++;
            if (duty !== 7'(m_duty) || level !== 4'(m_q.size()) || s_ready !== mo_rdy ||
                underrun !== m_ur || frame_start !== mo_fs) begin
                $display("FAIL state @cyc %0d: got duty=%0d level=%0d rdy=%b ur=%b fs=%b, expected duty=%0d level=%0d rdy=%b ur=%b fs=%b",
                         cyc, duty, level, s_ready, underrun, frame_start,
                         m_duty, m_q.size(), mo_rdy, m_ur, mo_fs);
                note_fail();
            end
            mo_dv = (exp_q.size() > 0);
            vectors++;
            if (duty_valid !== mo_dv) begin
                $display("FAIL duty_valid @cyc %0d: got %b expected %b", cyc, duty_valid, mo_dv);
                note_fail();
            end
            if (mo_dv) begin
                mo_e = exp_q.pop_front();
                if (duty_valid === 1'b1) begin
                    vectors++;
                    if (mo_e.c != cyc || mo_e.d != int'(duty)) begin
                        $display("FAIL duty_load @cyc %0d: got duty %0d expected duty %0d from cyc %0d",
                                 cyc, duty, mo_e.d, mo_e.c);
                        note_fail();
                    end
                end
            end
            if (duty_valid === 1'b1) dv_log.push_back(int'(duty));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i <= FL + 1; i++) begin
            if (m_t % FL == p) return;
            tick(1);
        end
        vectors++;
        $display("FAIL wait_pos: counter %0d never reached %0d", m_t % FL, p);
        note_fail();
    endtask

    task automatic push_one(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        vectors++;
        $display("FAIL push_timeout: got no s_ready expected s_ready within 400 cycles");
        note_fail();
    endtask

    initial begin
        int exp_seq[6];
        int pv;
        exp_seq = '{50, 50, 99, 0, 25, 50};
        rst = 1'b1; en = 1'b1; s_valid = 1'b0; s_data = '0; clr_underrun = 1'b0;

        // Reset and free-running frame counter.
        tick(3);
        chk("reset_duty", int'(duty), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_underrun", int'(underrun), 0);
        chk("reset_s_ready", int'(s_ready), 0);
        rst = 1'b0; #1;
        chk("ready_after_reset", int'(s_ready), 1);
        chk("frame_start_first", int'(frame_start), 1);
        en = 1'b0;
        tick(100);
        chk("frame_start_period", int'(frame_start), 1);
        tick(1);
        chk("frame_start_pulse", int'(frame_start), 0);
        tick(150);

        // Prime, run four samples, then underrun.
        dv_log.delete();
        wait_pos(1);
        en = 1'b1;
        push_one(8'd128); push_one(8'd255); push_one(8'd0); push_one(8'd64);
        for (int i = 0; i < 3000 && dv_log.size() < 6; i++) tick(1);
        chk("load_count", dv_log.size(), 6);
        for (int i = 0; i < 6 && i < dv_log.size(); i++) chk("load_seq", dv_log[i], exp_seq[i]);
        chk("underrun_set", int'(underrun), 1);
        clr_underrun = 1'b1; tick(1); clr_underrun = 1'b0;
        chk("underrun_clr", int'(underrun), 0);

        // Backpressure while priming.
        wait_pos(1);
        for (int i = 0; i < 8; i++) push_one(8'($urandom));
        chk("full_level", int'(level), 8);
        chk("full_not_ready", int'(s_ready), 0);
        push_one(8'd200);
        chk("ninth_after_pop", int'(level), 8);

        // Mid-frame disable with five buffered samples.
        en = 1'b0; tick(2); wait_pos(0);
        en = 1'b1; tick(1); wait_pos(0);
        for (int i = 0; i < 5; i++) push_one(8'($urandom));
        wait_pos(37);
        chk("level_pre_disable", int'(level), 5);
        en = 1'b0; tick(1);
        chk("level_flushed", int'(level), 0);
        chk("duty_held", int'(duty), IDLE_D);
        wait_pos(0);
        @(negedge clk);
        chk("disable_duty", int'(duty), 0);
        chk("disable_dv", int'(duty_valid), 1);

        // Reset in RUN with three buffered samples.
        tick(1); en = 1'b1;
        for (int i = 0; i < 4; i++) push_one(8'($urandom));
        wait_pos(0); tick(1); wait_pos(0);
        wait_pos(60);
        chk("level_pre_reset", int'(level), 3);
        rst = 1'b1; tick(1); rst = 1'b0; #1;
        chk("rst_level", int'(level), 0);
        chk("rst_duty", int'(duty), 0);
        chk("rst_counter", int'(frame_start), 1);

        // Randomized traffic: varying feed rate, rare enable toggles, clears and resets.
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: pv = 500;
                1: pv = 3;
                2: pv = 0;
                default: pv = 30;
            endcase
            for (int i = 0; i < 2000; i++) begin
                s_valid      = ($urandom % 1000) < pv;
                s_data       = 8'($urandom);
                clr_underrun = ($urandom % 300) == 0;
                rst          = ($urandom % 4000) == 0;
                if (en ? (($urandom % 900) == 0) : (($urandom % 60) == 0)) en = ~en;
                tick(1);
            end
        end
        s_valid = 1'b0; rst = 1'b0; clr_underrun = 1'b0;
        tick(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
